dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller that sits between the CPU's byte-wide load/store port and a block-wide (4-byte) data memory. Hits are served without stalling the CPU. Misses are sequenced through a writeback/fetch state machine that drives the memory's read/write/busywait handshake. The controller replaces the direct CPU-to-data-memory connection in the single-cycle CPU.

---
 rtl/dcache_pkg.sv | 36 +++
 rtl/dcache_store.sv | 57 +++++
 rtl/dcache_controller.sv | 175 +++++++++++++++++
 tb/tb_dcache_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, geometry constants and address helpers for the
// direct-mapped data cache (dcache_controller / dcache_store).
// Address layout (8-bit byte address): tag=[7:5], index=[4:2], offset=[1:0].
package dcache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 8;
  localparam int BLOCK_W  = 32;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_FILL      = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return addr_t'(addr);
  endfunction

  // Byte 'off' of a block; byte0 lives in bits [7:0].
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_store.sv
// dcache_store: valid/dirty/tag/data arrays of the direct-mapped cache.
// Ports:
//   clock, reset            : rising-edge clock, async active-high clear
//   lookup_index_i          : combinational lookup -> valid_o/dirty_o/tag_o/data_o
//   byte_we_i/_index/_offset/_data : synchronous byte write, marks line dirty
//   fill_i/_index/_tag/_data        : synchronous line fill, valid=1 dirty=0
// Fill has priority over a byte write (they never coincide in practice).
module dcache_store
  import dcache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  lookup_index_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [BLOCK_W-1:0]  data_o,
  input  logic                byte_we_i,
  input  logic [INDEX_W-1:0]  byte_index_i,
  input  logic [OFFSET_W-1:0] byte_offset_i,
  input  logic [7:0]          byte_data_i,
  input  logic                fill_i,
  input  logic [INDEX_W-1:0]  fill_index_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [BLOCK_W-1:0]  fill_data_i
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  assign valid_o = valid_q[lookup_index_i];
  assign dirty_o = dirty_q[lookup_index_i];
  assign tag_o   = tag_q[lookup_index_i];
  assign data_o  = data_q[lookup_index_i];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_i) begin
      valid_q[fill_index_i] <= 1'b1;
      dirty_q[fill_index_i] <= 1'b0;
      tag_q[fill_index_i]   <= fill_tag_i;
      data_q[fill_index_i]  <= fill_data_i;
    end else if (byte_we_i) begin
      dirty_q[byte_index_i] <= 1'b1;
      data_q[byte_index_i][{byte_offset_i, 3'b000} +: 8] <= byte_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// between a byte-wide CPU load/store port and a 32-bit block memory.
// Ports:
//   clock, reset (async, active-high)
//   CPU side : read, write, address[7:0], writedata[7:0] -> readdata[7:0], busywait
//   Mem side : mem_read, mem_write, mem_address[5:0], mem_writedata[31:0]
//              <- mem_readdata[31:0], mem_busywait
//   state_o  : current FSM state (dcache_pkg::state_e encoding), debug only
//   hit_count, miss_count [15:0] : only when DCACHE_STATS_EN is defined
// Handshake: CPU holds read/write (and address/data) while busywait=1; the
// cache holds mem_read/mem_write and mem_address/mem_writedata stable until
// mem_busywait is sampled low at a posedge, and drops them the next cycle.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned MEM_LATENCY_MAX = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic [1:0]  state_o
`ifdef DCACHE_STATS_EN
  , output logic [15:0] hit_count
  , output logic [15:0] miss_count
`endif
);

  state_e             state_q, state_d;
  addr_t              a;
  logic               req, hit;
  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic [BLOCK_W-1:0] fill_q;
  logic               byte_we, fill;

  assign a   = split_addr(address);
  assign req = read | write;
  assign hit = line_valid && (line_tag == a.tag);
  assign state_o = state_q;

  dcache_store u_store (
    .clock          (clock),
    .reset          (reset),
    .lookup_index_i (a.index),
    .valid_o        (line_valid),
    .dirty_o        (line_dirty),
    .tag_o          (line_tag),
    .data_o         (line_data),
    .byte_we_i      (byte_we),
    .byte_index_i   (a.index),
    .byte_offset_i  (a.offset),
    .byte_data_i    (writedata),
    .fill_i         (fill),
    .fill_index_i   (a.index),
    .fill_tag_i     (a.tag),
    .fill_data_i    (fill_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      // Capture the block on the completing FETCH edge so FILL does not
      // depend on the memory holding mem_readdata after it goes idle.
      if (state_q == S_FETCH && !mem_busywait) fill_q <= mem_readdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    busywait      = 1'b0;
    readdata      = 8'h00;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'h00;
    mem_writedata = 32'h0;
    byte_we       = 1'b0;
    fill          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // read+write together behaves as a write
            byte_we = write;
            if (!write) readdata = block_byte(line_data, a.offset);
          end else begin
            busywait = 1'b1;
            state_d  = line_dirty ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {line_tag, a.index};
        mem_writedata = line_data;
        // A dropped request still finishes the writeback, then gives up.
        if (!mem_busywait) state_d = req ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {a.tag, a.index};
        if (!mem_busywait) state_d = req ? S_FILL : S_IDLE;
      end
      S_FILL: begin
        busywait = 1'b1;
        fill     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // State is forced to IDLE asynchronously; keep the CPU side quiet too
    // while reset is held even if a request is still presented.
    if (reset) begin
      busywait = 1'b0;
      readdata = 8'h00;
      byte_we  = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        just_filled_q;
  logic [15:0] hit_q, miss_q;
  logic        decide;

  assign decide = (state_q == S_IDLE) && req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      just_filled_q <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      // The hit that completes a miss belongs to the already-counted miss.
      just_filled_q <= (state_q == S_FILL);
      if (decide && hit && !just_filled_q && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      if (decide && !hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

`ifndef SYNTHESIS
  logic [15:0] wd_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wd_q <= '0;
    else if ((state_q == S_WRITEBACK || state_q == S_FETCH) && mem_busywait) begin
      if (wd_q != 16'hFFFF) wd_q <= wd_q + 16'd1;
    end else wd_q <= '0;
  end

  a_mem_watchdog: assert property (@(posedge clock) disable iff (reset)
    32'(wd_q) < MEM_LATENCY_MAX);
  a_mem_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(mem_read && mem_write));
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed bench with a latency-N block memory model,
// expected queues for CPU load data and memory transactions, and a monitor
// that pops/compares whenever the DUT presents a result.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int LAT = 5;
  localparam int STALL_BOUND = 200;
  localparam int MISS_CLEAN = 1 + LAT + 1;        // IDLE decision + FETCH + FILL
  localparam int MISS_DIRTY = 1 + LAT + LAT + 1;  // + WRITEBACK

  logic        clock, reset;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait;
  logic        mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [1:0]  state_o;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_controller #(.MEM_LATENCY_MAX(64)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .state_o(state_o)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [31:0] mem_blk [64];
  int          mcnt;

  assign mem_busywait = (mem_read || mem_write) && (mcnt != LAT - 1);
  assign mem_readdata = mem_blk[mem_address];

  always @(posedge clock) begin
    if (reset) mcnt <= 0;
    else if (mem_read || mem_write) begin
      if (mcnt == LAT - 1) begin
        mcnt <= 0;
        if (mem_write) mem_blk[mem_address] <= mem_writedata;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [7:0]  exp_q[$];      // expected load data
  logic [38:0] mem_exp_q[$];  // {is_write, block address, writeback data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_mem(input logic is_wr, input logic [5:0] addr, input logic [31:0] data);
    mem_exp_q.push_back({is_wr, addr, data});
  endtask

  // monitor: compares whatever the DUT presents against the queues
  always @(negedge clock) begin
    logic [7:0]  e8;
    logic [38:0] em;
    if (!reset) begin
      if (read && !write && !busywait) begin
        if (exp_q.size() == 0) check("unexpected_load", {24'h0, readdata}, 32'h0 - 1);
        else begin
          e8 = exp_q.pop_front();
          check("readdata", {24'h0, readdata}, {24'h0, e8});
        end
      end
      if ((mem_read || mem_write) && !mem_busywait) begin
        if (mem_exp_q.size() == 0) check("unexpected_mem_txn", {26'h0, mem_address}, 32'h0 - 1);
        else begin
          em = mem_exp_q.pop_front();
          check("mem_rw_exclusive", {30'h0, mem_read, mem_write}, em[38] ? 32'h1 : 32'h2);
          check("mem_address", {26'h0, mem_address}, {26'h0, em[37:32]});
          if (em[38]) check("mem_writedata", mem_writedata, em[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a posedge; returns just after a posedge.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, input int exp_stalls, input logic [7:0] exp_rd);
    int stalls;
    if (rd && !wr) exp_q.push_back(exp_rd);
    if (exp_stalls == 0) exp_hits++; else exp_misses++;
    read = rd; write = wr; address = addr; writedata = wd;
    stalls = 0;
    @(negedge clock);
    while (busywait && stalls < STALL_BOUND) begin
      stalls++;
      @(negedge clock);
    end
    check("stall_cycles", stalls, exp_stalls);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem_blk[i] = {2'b00, i[5:0], 24'h0F0F0F};
    mem_blk[6'h09] = 32'hDDCCBBAA;
    mem_blk[6'h11] = 32'h87654321;
    mem_blk[6'h19] = 32'hA1B2C3D4;
    mem_blk[6'h00] = 32'h44332211;

    reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_busywait",      {31'h0, busywait},  32'h0);
    check("rst_readdata",      {24'h0, readdata},  32'h0);
    check("rst_mem_read",      {31'h0, mem_read},  32'h0);
    check("rst_mem_write",     {31'h0, mem_write}, 32'h0);
    check("rst_mem_address",   {26'h0, mem_address}, 32'h0);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    check("rst_state",         {30'h0, state_o}, {30'h0, S_IDLE});
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // cold read: line 1 fetched from block 0x09, byte 1
    expect_mem(1'b0, 6'h09, 32'h0);
    access(1'b1, 1'b0, 8'h25, 8'h00, MISS_CLEAN, 8'hBB);
    // write hit then read-back, plus neighbouring bytes
    access(1'b0, 1'b1, 8'h27, 8'h5A, 0, 8'h00);
    access(1'b1, 1'b0, 8'h27, 8'h00, 0, 8'h5A);
    access(1'b1, 1'b0, 8'h25, 8'h00, 0, 8'hBB);
    access(1'b1, 1'b0, 8'h24, 8'h00, 0, 8'hAA);
    // dirty eviction of line 1 by tag 2
    expect_mem(1'b1, 6'h09, 32'h5ACCBBAA);
    expect_mem(1'b0, 6'h11, 32'h0);
    access(1'b1, 1'b0, 8'h45, 8'h00, MISS_DIRTY, 8'h43);
    // the written-back block must come back with the stored byte
    expect_mem(1'b0, 6'h09, 32'h0);
    access(1'b1, 1'b0, 8'h27, 8'h00, MISS_CLEAN, 8'h5A);
    // offset coverage on line 0
    expect_mem(1'b0, 6'h00, 32'h0);
    access(1'b1, 1'b0, 8'h00, 8'h00, MISS_CLEAN, 8'h11);
    access(1'b1, 1'b0, 8'h01, 8'h00, 0, 8'h22);
    access(1'b1, 1'b0, 8'h02, 8'h00, 0, 8'h33);
    access(1'b1, 1'b0, 8'h03, 8'h00, 0, 8'h44);
    access(1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h11);

`ifdef DCACHE_STATS_EN
    @(negedge clock);
    check("hit_count",  {16'h0, hit_count},  exp_hits);
    check("miss_count", {16'h0, miss_count}, exp_misses);
    @(posedge clock); #1;
`endif

    // reset in the middle of a FETCH for 0x65 (block 0x19)
    address = 8'h65; read = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("pre_rst_state",    {30'h0, state_o}, {30'h0, S_FETCH});
    check("pre_rst_mem_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_mem_read", {31'h0, mem_read}, 32'h0);
    check("midrst_busywait", {31'h0, busywait}, 32'h0);
    check("midrst_state",    {30'h0, state_o}, {30'h0, S_IDLE});
    repeat (2) @(posedge clock);
    #1;
    read = 1'b0; reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
    @(posedge clock); #1;

    expect_mem(1'b0, 6'h19, 32'h0);
    access(1'b1, 1'b0, 8'h65, 8'h00, MISS_CLEAN, 8'hC3);
    // line 0 was cleared by reset, so this must miss again
    expect_mem(1'b0, 6'h00, 32'h0);
    access(1'b1, 1'b0, 8'h00, 8'h00, MISS_CLEAN, 8'h11);
    access(1'b1, 1'b0, 8'h66, 8'h00, 0, 8'hB2);

    repeat (3) @(posedge clock);
    @(negedge clock);
`ifdef DCACHE_STATS_EN
    check("hit_count_after_rst",  {16'h0, hit_count},  exp_hits);
    check("miss_count_after_rst", {16'h0, miss_count}, exp_misses);
`endif
    check("load_queue_drained", exp_q.size(), 32'h0);
    check("mem_queue_drained",  mem_exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
